fetch_stage: RTL

- First pipeline stage. Owns the program counter, issues one instruction-memory read at a time, and presents the fetched instruction to decode_stage over the done_next/next_stall handshake.
- Accepts redirects (branch/jump targets) resolved in decode. On a redirect it squashes the wrong-path instruction it holds and any in-flight fetch, then restarts at the target.

---
 rtl/fetch_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory read in flight
// and hands fetched words to decode over the done_next/next_stall handshake.
module fetch_stage #(
    parameter int unsigned           ADDR_WIDTH        = 32,
    parameter int unsigned           INSTRUCTION_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR      = ADDR_WIDTH'(32'h0000_0000)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         next_stall,
    output logic                         done_next,
    input  logic                         control_flow_affected,
    input  logic [ADDR_WIDTH-1:0]        jump_target,
    input  logic                         jump_target_valid,
    input  logic                         redirect_enable,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [ADDR_WIDTH-1:0]        imem_req_addr,
    input  logic                         imem_resp_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_resp_data,
    input  logic                         imem_resp_error,
    output logic [ADDR_WIDTH-1:0]        program_count_out,
    output logic                         program_count_valid_out,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_data_out,
    output logic                         instruction_data_valid_out
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]          req_pc_q, req_pc_d;
    logic                           stale_q, stale_d;

    logic                           out_valid_q;
    logic [ADDR_WIDTH-1:0]          out_pc_q;
    logic [INSTRUCTION_WIDTH-1:0]   out_instr_q;
    logic                           out_instr_valid_q;

    logic                           redirect;
    logic                           transfer_next;
    logic                           slot_free;
    logic                           misaligned;
    logic                           req_valid_c;
    logic                           load_fetch;
    logic                           load_misalign;

    assign redirect      = control_flow_affected && jump_target_valid && redirect_enable;
    assign done_next     = out_valid_q && !redirect;
    assign transfer_next = done_next && !next_stall;
    assign slot_free     = !out_valid_q || transfer_next;
    assign misaligned    = (pc_q[1:0] != 2'b00);

    // Request is masked while reset is held so the bus sees no request during reset.
    assign imem_req_valid = rst_n && req_valid_c;
    assign imem_req_addr  = pc_q;

    assign program_count_out          = out_pc_q;
    assign program_count_valid_out    = out_valid_q;
    assign instruction_data_out       = out_instr_q;
    assign instruction_data_valid_out = out_instr_valid_q;

    // Fetch sequencing: request issue, response/stale handling, PC update.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        stale_d       = stale_q;
        req_valid_c   = 1'b0;
        load_fetch    = 1'b0;
        load_misalign = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (!redirect && slot_free) begin
                    if (misaligned) begin
                        load_misalign = 1'b1;
                        pc_d          = pc_q + PC_STEP;
                    end else begin
                        req_valid_c = 1'b1;
                        if (imem_req_ready) begin
                            req_pc_d = pc_q;
                            state_d  = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                    stale_d = 1'b0;
                    if (!stale_q && !redirect) begin
                        load_fetch = 1'b1;
                        pc_d       = req_pc_q + PC_STEP;
                    end
                end else if (redirect) begin
                    stale_d = 1'b1;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect) begin
            pc_d = jump_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_VECTOR;
            req_pc_q <= RESET_VECTOR;
            stale_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            stale_q  <= stale_d;
        end
    end

    // Output register: flushed on redirect, reload beats drain, held under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q       <= 1'b0;
            out_pc_q          <= '0;
            out_instr_q       <= '0;
            out_instr_valid_q <= 1'b0;
        end else if (redirect) begin
            out_valid_q       <= 1'b0;
            out_instr_valid_q <= 1'b0;
        end else if (load_fetch) begin
            out_valid_q       <= 1'b1;
            out_pc_q          <= req_pc_q;
            out_instr_q       <= imem_resp_data;
            out_instr_valid_q <= !imem_resp_error;
        end else if (load_misalign) begin
            out_valid_q       <= 1'b1;
            out_pc_q          <= pc_q;
            out_instr_q       <= '0;
            out_instr_valid_q <= 1'b0;
        end else if (transfer_next) begin
            out_valid_q       <= 1'b0;
            out_instr_valid_q <= 1'b0;
        end
    end

endmodule
